uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rr_arbiter4.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 99 +++++++++
 tb/tb_uart_tx_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
// Frame length covers start, data, parity and stop bits plus handshake slack.
package uart_pkg;

    localparam int unsigned BIT_CYCLES = 2501;
    localparam int unsigned FRAME_BITS = 11;

    function automatic int unsigned frame_cycles(input int unsigned bit_cycles);
        return FRAME_BITS * bit_cycles + 3;
    endfunction

    localparam int unsigned FRAME_CYCLES = frame_cycles(BIT_CYCLES);

    typedef enum logic [1:0] {
        GUARD = 2'd0,
        IDLE  = 2'd1,
        SEND  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin selector: first set request searching upward from last+1.
// Purely combinational; the caller registers the result.
module rr_arbiter4
    import uart_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = last;
        cand  = last;
        // i == 4 wraps back to last itself, so it has the lowest priority
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last + i[1:0];
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter; enforces a full-frame guard
// between start pulses and after reset, since the transmitter itself is never reset.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned BIT_CYCLES   = uart_pkg::BIT_CYCLES,
    parameter int unsigned FRAME_CYCLES = uart_pkg::frame_cycles(BIT_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic [1:0]           owner
);

    import uart_pkg::*;

    localparam int unsigned       TIMER_W    = $clog2(FRAME_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FRAME_CYCLES - 1);

    arb_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [N_REQ-1:0]   grant_d;
    logic               tx_start_d;
    logic [7:0]         tx_data_d;
    logic [1:0]         owner_d;
    logic               busy_d;

    logic               arb_valid;
    logic [1:0]         arb_idx;

    rr_arbiter4 u_rr (
        .req   (req),
        .last  (owner),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= GUARD;
            timer_q  <= '0;
            grant    <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'hFF;
            owner    <= 2'd3;
            busy     <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            grant    <= grant_d;
            tx_start <= tx_start_d;
            tx_data  <= tx_data_d;
            owner    <= owner_d;
            busy     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        grant_d    = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data;
        owner_d    = owner;

        case (state_q)
            GUARD, SEND: begin
                if (timer_q == TIMER_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            IDLE: begin
                // Data is captured only here, on the accepting edge
                if (arb_valid) begin
                    state_d          = SEND;
                    timer_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                    tx_start_d       = 1'b1;
                    tx_data_d        = req_data[{arb_idx, 3'b000} +: 8];
                    owner_d          = arb_idx;
                end
            end
            default: begin
                state_d = GUARD;
                timer_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a shortened 20-cycle frame.
// Stimulus pushes expected grants; the negedge monitor checks every cycle.
module tb_uart_tx_arbiter;

    localparam int FC = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  owner;

    uart_tx_arbiter #(
        .N_REQ        (4),
        .BIT_CYCLES   (2),
        .FRAME_CYCLES (FC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .busy     (busy),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] grant;
        logic [7:0] data;
        logic [1:0] owner;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         cyc = 0;
    int         ref_cyc = 0;
    int         diff;
    logic [7:0] last_data = 8'hFF;
    logic [1:0] last_owner = 2'd3;
    logic       prev_start = 1'b0;
    bit         done = 1'b0;
    int         n_checks = 0;
    int         n_errs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_start(input logic [3:0] g, input logic [7:0] d, input logic [1:0] o);
        exp_t x;
        x.grant = g;
        x.data  = d;
        x.owner = o;
        exp_q.push_back(x);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: reset values, scoreboard pops on tx_start, invariants every cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_grant", int'(grant), 0);
            chk("rst_tx_start", int'(tx_start), 0);
            chk("rst_tx_data", int'(tx_data), 'hFF);
            chk("rst_owner", int'(owner), 3);
            chk("rst_busy", int'(busy), 1);
            ref_cyc    = cyc + 1;
            last_data  = 8'hFF;
            last_owner = 2'd3;
            prev_start = 1'b0;
        end else begin
            if (tx_start) begin
                chk("start_twice", int'(prev_start), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", int'(grant), 0);
                    chk("unexpected_start_flag", int'(tx_start), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", int'(grant), int'(e.grant));
                    chk("tx_data", int'(tx_data), int'(e.data));
                    chk("owner", int'(owner), int'(e.owner));
                    chk("start_gap", cyc - ref_cyc, FC + 1);
                end
                ref_cyc    = cyc;
                last_data  = tx_data;
                last_owner = owner;
            end else begin
                chk("grant_idle", int'(grant), 0);
                chk("tx_data_stable", int'(tx_data), int'(last_data));
                chk("owner_stable", int'(owner), int'(last_owner));
            end
            diff = cyc - ref_cyc;
            chk("busy", int'(busy), (diff < FC) ? 1 : 0);
            prev_start = tx_start;
        end
        if (done) begin
            chk("queue_empty", exp_q.size(), 0);
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
            $finish;
        end
    end

    initial begin
        // Reset with requester 0 already waiting: first grant only after the guard
        #1;
        rst_n    = 1'b0;
        req      = 4'b0001;
        req_data = 32'h0000_00A5;
        expect_start(4'b0001, 8'hA5, 2'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(24);
        req = 4'b0000;

        // One-cycle reset five cycles into SEND, then all four requesters held
        wait_cyc(29);
        rst_n = 1'b0;
        wait_cyc(30);
        rst_n    = 1'b1;
        req      = 4'b1111;
        req_data = 32'h4433_2211;
        expect_start(4'b0001, 8'h11, 2'd0);
        expect_start(4'b0010, 8'h22, 2'd1);
        expect_start(4'b0100, 8'h33, 2'd2);
        expect_start(4'b1000, 8'h44, 2'd3);
        expect_start(4'b0001, 8'h11, 2'd0);

        // Move owner to 1, then requesters 0 and 2 compete
        wait_cyc(135);
        req = 4'b0010;
        expect_start(4'b0010, 8'h22, 2'd1);
        wait_cyc(156);
        req      = 4'b0101;
        req_data = 32'h44C3_225A;
        expect_start(4'b0100, 8'hC3, 2'd2);
        expect_start(4'b0001, 8'h5A, 2'd0);
        wait_cyc(177);
        req = 4'b0001;
        wait_cyc(198);
        req = 4'b0000;

        // Short req[3] pulse during SEND must be ignored
        wait_cyc(203);
        req = 4'b1000;
        wait_cyc(206);
        req = 4'b0000;

        wait_cyc(240);
        done = 1'b1;
    end

endmodule
